// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller.
// Contents: FSM state encoding, parity type codes and the idle line level.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      STR  = 3'b001,
      DATA = 3'b010,
      PAR  = 3'b011,
      STP  = 3'b100
   } state_e;

   localparam logic PAR_EVEN    = 1'b0;
   localparam logic PAR_ODD     = 1'b1;
   localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   start         frame accept; loads prescale and restarts the period
//   prescale      clk cycles per bit (0 behaves as 1)
//   bit_end       high on the last cycle of each bit period
//   bit_end_nxt   bit_end value for the following cycle
module uart_tx_bit_timer #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_end,
   output logic                  bit_end_nxt
);

   // Counters hold (period - 1) so a prescale of 0 or 1 both give one-cycle bits.
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [PRESCALE_W-1:0] reload_q, reload_d;
   logic [PRESCALE_W-1:0] reload_in;

   always_comb begin
      reload_in = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
      reload_d  = reload_q;
      if (start) begin
         reload_d = reload_in;
         cnt_d    = reload_in;
      end else if (cnt_q == '0) begin
         cnt_d = reload_q;
      end else begin
         cnt_d = cnt_q - PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         reload_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

   assign bit_end     = (cnt_q == '0);
   assign bit_end_nxt = (cnt_d == '0);

endmodule

// File: rtl/uart_tx_ctrl_gen.sv
// UART transmit controller: FSM, serializer, parity and bit timing.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   P_DATA        payload, sent LSB first
//   Data_valid    send request (honoured in IDLE or on the Frame_done cycle)
//   Par_en        insert parity bit
//   Par_typ       0 = even, 1 = odd parity
//   Stop2         two stop bits when set
//   Prescale      clk cycles per bit, 0 behaves as 1
//   TX_OUT        serial line, idle high
//   Busy          frame in progress
//   Frame_done    pulse on the last cycle of the final stop bit
module uart_tx_ctrl_gen
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_valid,
   input  logic                  Par_en,
   input  logic                  Par_typ,
   input  logic                  Stop2,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  TX_OUT,
   output logic                  Busy,
   output logic                  Frame_done
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  parity_q, parity_d;
   logic                  stop2_q, stop2_d;
   logic                  stop_last_q, stop_last_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  accept;
   logic                  bit_end, bit_end_nxt;

   uart_tx_bit_timer #(
      .PRESCALE_W (PRESCALE_W)
   ) u_bit_timer (
      .clk         (clk),
      .rst         (rst),
      .start       (accept),
      .prescale    (Prescale),
      .bit_end     (bit_end),
      .bit_end_nxt (bit_end_nxt)
   );

   // done_q marks the final stop cycle, which doubles as the back-to-back accept slot.
   assign accept = Data_valid && ((state_q == IDLE) || done_q);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      par_en_d    = par_en_q;
      parity_d    = parity_q;
      stop2_d     = stop2_q;
      stop_last_d = stop_last_q;
      tx_d        = tx_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            tx_d   = TX_IDLE_LVL;
            busy_d = 1'b0;
         end
         STR: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               cnt_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (cnt_q == LAST_BIT) begin
                  if (par_en_q) begin
                     state_d = PAR;
                     tx_d    = parity_q;
                  end else begin
                     state_d     = STP;
                     tx_d        = TX_IDLE_LVL;
                     stop_last_d = !stop2_q;
                  end
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_d     = STP;
               tx_d        = TX_IDLE_LVL;
               stop_last_d = !stop2_q;
            end
         end
         STP: begin
            if (bit_end) begin
               if (stop_last_q) begin
                  state_d = IDLE;
                  tx_d    = TX_IDLE_LVL;
                  busy_d  = 1'b0;
               end else begin
                  stop_last_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = TX_IDLE_LVL;
            busy_d  = 1'b0;
         end
      endcase

      if (accept) begin
         state_d  = STR;
         tx_d     = 1'b0;
         busy_d   = 1'b1;
         shift_d  = P_DATA;
         par_en_d = Par_en;
         parity_d = (^P_DATA) ^ (Par_typ == PAR_ODD);
         stop2_d  = Stop2;
      end

      // Registered pulse: predict that the next cycle closes the final stop bit.
      done_d = (state_d == STP) && stop_last_d && bit_end_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         par_en_q    <= 1'b0;
         parity_q    <= 1'b0;
         stop2_q     <= 1'b0;
         stop_last_q <= 1'b0;
         tx_q        <= TX_IDLE_LVL;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         par_en_q    <= par_en_d;
         parity_q    <= parity_d;
         stop2_q     <= stop2_d;
         stop_last_q <= stop_last_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign TX_OUT     = tx_q;
   assign Busy       = busy_q;
   assign Frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl_gen.sv
// Self-checking bench for uart_tx_ctrl_gen: an 8-bit and a 5-bit instance,
// a frame-level expectation queue per instance and literal per-test pins.
module tb_uart_tx_ctrl_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pd8 = '0;
   logic [4:0] pd5 = '0;
   logic       dv8 = 1'b0;
   logic       dv5 = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       stop2 = 1'b0;
   logic [7:0] prescale = 8'd1;
   logic       tx8, busy8, done8;
   logic       tx5, busy5, done5;

   typedef struct {
      bit tx;
      bit busy;
      bit done;
   } exp_t;

   exp_t q8[$];
   exp_t q5[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   cap_tx8[64];
   bit   cap_busy8[64];
   bit   cap_done8[64];
   bit   cap_tx5[64];
   bit   cap_busy5[64];

   uart_tx_ctrl_gen #(.DATA_WIDTH(8), .PRESCALE_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .P_DATA(pd8), .Data_valid(dv8), .Par_en(par_en),
      .Par_typ(par_typ), .Stop2(stop2), .Prescale(prescale),
      .TX_OUT(tx8), .Busy(busy8), .Frame_done(done8)
   );

   uart_tx_ctrl_gen #(.DATA_WIDTH(5), .PRESCALE_W(8)) u_dut5 (
      .clk(clk), .rst(rst), .P_DATA(pd5), .Data_valid(dv5), .Par_en(par_en),
      .Par_typ(par_typ), .Stop2(stop2), .Prescale(prescale),
      .TX_OUT(tx5), .Busy(busy5), .Frame_done(done5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected line activity for one frame: list the bits, then stretch each by the period.
   task automatic model_frame(input int which, input int width, input logic [8:0] data,
                              input bit pe, input bit pt, input bit s2, input int pre);
      bit   bits[$];
      int   p;
      int   ones;
      exp_t e;
      p    = (pre == 0) ? 1 : pre;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < width; i++) begin
         bits.push_back(data[i]);
         ones += int'(data[i]);
      end
      if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      for (int b = 0; b < bits.size(); b++) begin
         for (int r = 0; r < p; r++) begin
            e.tx   = bits[b];
            e.busy = 1'b1;
            e.done = (b == bits.size() - 1) && (r == p - 1);
            if (which == 8) q8.push_back(e);
            else q5.push_back(e);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns 1 ns after the accept edge.
   task automatic send(input int which, input logic [8:0] data, input bit pe, input bit pt,
                       input bit s2, input logic [7:0] pre);
      par_en   = pe;
      par_typ  = pt;
      stop2    = s2;
      prescale = pre;
      if (which == 8) begin
         pd8 = data[7:0];
         dv8 = 1'b1;
      end else begin
         pd5 = data[4:0];
         dv5 = 1'b1;
      end
      @(posedge clk);
      model_frame(which, (which == 8) ? 8 : 5, data, pe, pt, s2, int'(pre));
      #1;
      dv8 = 1'b0;
      dv5 = 1'b0;
   endtask

   task automatic cap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_tx8[i]   = tx8;
         cap_busy8[i] = busy8;
         cap_done8[i] = done8;
         cap_tx5[i]   = tx5;
         cap_busy5[i] = busy5;
      end
   endtask

   function automatic int count_busy8(input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) c += int'(cap_busy8[i]);
      return c;
   endfunction

   function automatic int count_tx8(input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) c += int'(cap_tx8[i]);
      return c;
   endfunction

   always @(negedge clk) begin : cmp
      exp_t e8;
      exp_t e5;
      if (rst) begin
         e8 = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
         e5 = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
         if (q8.size() > 0) e8 = q8.pop_front();
         if (q5.size() > 0) e5 = q5.pop_front();
         chk("w8 TX_OUT", int'(tx8), int'(e8.tx));
         chk("w8 Busy", int'(busy8), int'(e8.busy));
         chk("w8 Frame_done", int'(done8), int'(e8.done));
         chk("w5 TX_OUT", int'(tx5), int'(e5.tx));
         chk("w5 Busy", int'(busy5), int'(e5.busy));
         chk("w5 Frame_done", int'(done5), int'(e5.done));
      end
   end

   initial begin
      bit t1_exp[11];
      bit t6_exp[7];
      t1_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      t6_exp = '{0, 1, 1, 0, 0, 1, 1};

      // Reset state, asynchronously applied
      #1 rst = 1'b0;
      #2;
      chk("reset TX_OUT", int'(tx8), 1);
      chk("reset Busy", int'(busy8), 0);
      chk("reset Frame_done", int'(done8), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      step(3);

      // 1: A5, even parity, one stop, prescale 1
      send(8, 9'h0A5, 1'b1, 1'b0, 1'b0, 8'd1);
      cap(12);
      for (int i = 0; i < 11; i++) chk($sformatf("t1 bit%0d", i), int'(cap_tx8[i]),
                                       int'(t1_exp[i]));
      chk("t1 busy cycles", count_busy8(0, 11), 11);
      chk("t1 done on cycle 11", int'(cap_done8[10]), 1);
      chk("t1 done not early", int'(cap_done8[9]), 0);
      step(3);

      // 2: 03, odd parity, two stops, prescale 4
      send(8, 9'h003, 1'b1, 1'b1, 1'b1, 8'd4);
      cap(50);
      chk("t2 busy cycles", count_busy8(0, 49), 48);
      chk("t2 d1 last cycle", int'(cap_tx8[11]), 1);
      chk("t2 d2 first cycle", int'(cap_tx8[12]), 0);
      chk("t2 parity bit", int'(cap_tx8[36]), 1);
      chk("t2 last 8 high", count_tx8(40, 47), 8);
      chk("t2 done cycle 48", int'(cap_done8[47]), 1);
      step(2);

      // 3: back-to-back 55 then AA, no parity, prescale 2
      send(8, 9'h055, 1'b0, 1'b0, 1'b0, 8'd2);
      fork
         cap(44);
         begin
            step(19);
            send(8, 9'h0AA, 1'b0, 1'b0, 1'b0, 8'd2);
         end
      join
      chk("t3 busy unbroken", count_busy8(0, 39), 40);
      chk("t3 busy after", int'(cap_busy8[40]), 0);
      chk("t3 done frame1", int'(cap_done8[19]), 1);
      chk("t3 stop then start", int'(cap_tx8[20]), 0);
      chk("t3 done frame2", int'(cap_done8[39]), 1);
      step(3);

      // 4: mid-frame request and config changes are ignored
      send(8, 9'h000, 1'b0, 1'b0, 1'b0, 8'd1);
      step(3);
      pd8      = 8'hFF;
      dv8      = 1'b1;
      prescale = 8'd7;
      par_en   = 1'b1;
      step(1);
      dv8    = 1'b0;
      par_en = 1'b0;
      step(12);

      // 5: reset during data bit 3 of A5 at prescale 4
      send(8, 9'h0A5, 1'b0, 1'b0, 1'b0, 8'd4);
      step(16);
      chk("t5 pre-reset TX_OUT", int'(tx8), 0);
      rst = 1'b0;
      #1;
      chk("t5 async TX_OUT", int'(tx8), 1);
      chk("t5 async Busy", int'(busy8), 0);
      q8.delete();
      step(2);
      rst = 1'b1;
      step(6);

      // 6: 5-bit instance, 13, prescale 0 treated as 1
      send(5, 9'h013, 1'b0, 1'b0, 1'b0, 8'd0);
      cap(8);
      for (int i = 0; i < 7; i++) chk($sformatf("t6 bit%0d", i), int'(cap_tx5[i]),
                                      int'(t6_exp[i]));
      chk("t6 busy ends", int'(cap_busy5[7]), 0);
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_ctrl_gen.md
Name: uart_tx_ctrl_gen

Overview:
Parametrised UART transmit controller: next generation of the UART TX FSM with serializer, parity generation and bit timing integrated in one block. Supports configurable data width, even/odd/no parity, 1 or 2 stop bits, a runtime bit-period prescaler and back-to-back frames with no idle gap. Sits between the register/FIFO front-end and the TX pad.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 legal)
PRESCALE_W, 8, width of the Prescale port (clk cycles per bit)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
P_DATA  in  DATA_WIDTH  parallel payload, sent LSB first
Data_valid  in  1  request to send P_DATA
Par_en  in  1  1 = parity bit inserted
Par_typ  in  1  0 = even, 1 = odd parity
Stop2  in  1  1 = two stop bits, 0 = one
Prescale  in  PRESCALE_W  clk cycles per bit; 0 treated as 1
TX_OUT  out  1  serial line, idle high
Busy  out  1  frame in progress
Frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async, rst=0): state IDLE, TX_OUT=1, Busy=0, Frame_done=0, counters cleared. Takes effect immediately, including mid-frame; no partial frame is completed.
- All outputs are registered and change on the same edge as the state.
- States: IDLE, STR, DATA, PAR, STP.
- Accept: in IDLE, Data_valid=1 at a rising edge latches P_DATA, Par_en, Par_typ, Stop2 and Prescale. On that edge the block enters STR with TX_OUT=0 and Busy=1. Latency from accept edge to start bit is 0 cycles.
- Every bit is held for exactly max(Prescale,1) cycles. The bit counter reloads at each bit boundary.
- STR -> DATA after one bit period.
- DATA shifts out DATA_WIDTH bits, LSB first. After the last bit: go to PAR if Par_en=1, else STP.
- PAR drives XOR of the latched data, inverted when Par_typ=1 (odd). Then go to STP.
- STP drives TX_OUT=1 for 1 or 2 bit periods, per latched Stop2. Frame_done=1 on the final cycle of the final stop bit.
- Frame length is (1 + DATA_WIDTH + Par_en + 1 + Stop2) x max(Prescale,1) cycles.
- End of frame, Data_valid=0 on the Frame_done cycle: go to IDLE, Busy=0, TX_OUT=1.
- End of frame, Data_valid=1 on the Frame_done cycle (back-to-back): the new frame is accepted on that edge and the block goes directly to STR. Busy stays 1 and there is no idle cycle.
- Data_valid is ignored while Busy=1, except on the Frame_done cycle. Upstream holds data until Busy falls or Frame_done is seen.
- Changes to config inputs mid-frame have no effect; they are sampled at accept only.
- Illegal state encodings recover to IDLE with TX_OUT=1 and Busy=0.

Decomposition:
- Shared package uart_tx_pkg holds:
  - state encoding localparams IDLE=3'b000, STR=3'b001, DATA=3'b010, PAR=3'b011, STP=3'b100
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1
  - TX_IDLE_LVL=1'b1
- One sub-module: uart_tx_bit_timer.
  - Loads the latched prescale value and emits bit_end on the last cycle of each bit period.
  - Restarts on frame accept.
- The FSM, shift register, data-bit counter and parity live in the top level.

Test Plan:
1. DATA_WIDTH=8, P_DATA=8'hA5, Par_en=1, Par_typ=0, Stop2=0, Prescale=1 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1. Busy high for 11 cycles. Frame_done pulses on cycle 11.
2. P_DATA=8'h03, Par_en=1, Par_typ=1, Stop2=1, Prescale=4 -> frame is 48 cycles. Each bit is stable for 4 cycles. Parity bit = 1. Last 8 cycles are high.
3. Back-to-back: 8'h55 then 8'hAA, second Data_valid asserted on the Frame_done cycle, Par_en=0, Prescale=2 -> the start bit of frame 2 follows the stop bit directly. Busy never drops. Total 40 cycles.
4. Data_valid pulsed with P_DATA=8'hFF mid-frame while sending 8'h00 -> the current frame is unchanged and 8'hFF is never transmitted.
5. rst asserted during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately, without waiting for a clock. After release, IDLE stays until the next Data_valid.
6. DATA_WIDTH=5 instance, P_DATA=5'h13, Par_en=0, Prescale=0 -> treated as 1. TX_OUT = 0,1,1,0,0,1,1 over 7 cycles.
